iomem_responder: RTL and testbench

Word-addressed SRAM target for the `iomem` valid/ready bus: the responder end of the bus the instruction cache and other initiators drive on a miss. It accepts one request at a time, services reads and byte-masked writes from an internal synchronous RAM after a programmable number of wait states, and returns a single-cycle `iomem_ready` pulse. It serves as the instruction/data backing store in simulation and small FPGA builds.

---
 rtl/iomem_responder.sv | 110 +++++++++++
 tb/tb_iomem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/iomem_responder.sv
// Word-addressed SRAM responder for the iomem valid/ready bus: one request at a time,
// WAIT_CYCLES wait states, single-cycle ready pulse. Optional address checking: IOMEM_RESP_ERR_EN.
module iomem_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        iomem_err
);

  localparam int          DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                state, state_next;
  logic                  accept;
  logic [7:0]            wait_cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic [31:0]           rd_q;
  logic                  addr_err;
  logic                  ram_we;
  logic [31:0]           mem [DEPTH];

`ifdef IOMEM_RESP_ERR_EN
  assign addr_err = (iomem_addr[31:DEPTH_LOG2+2] != BASE_ADDR[31:DEPTH_LOG2+2]);
  logic unused_ok;
  assign unused_ok = ^iomem_addr[1:0];
`else
  // Upper address bits are ignored so out-of-range addresses alias by index.
  assign addr_err = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{iomem_addr[31:DEPTH_LOG2+2], iomem_addr[1:0], BASE_ADDR};
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (iomem_valid) begin
          accept     = 1'b1;
          state_next = (WAIT_INIT != 8'd0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT:   if (wait_cnt <= 8'd1) state_next = S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
      rd_q     <= 32'd0;
    end else begin
      if (accept) begin
        idx_q    <= iomem_addr[DEPTH_LOG2+1:2];
        wstrb_q  <= iomem_wstrb;
        wdata_q  <= iomem_wdata;
        err_q    <= addr_err;
        wait_cnt <= WAIT_INIT;
      end
      if (state == S_WAIT) wait_cnt <= wait_cnt - 8'd1;
      if (state == S_ACCESS)
        rd_q <= (wstrb_q == 4'd0 && !err_q) ? mem[idx_q] : 32'd0;
    end
  end

  // A write whose ACCESS edge coincides with reset is dropped.
  assign ram_we = (state == S_ACCESS) && (wstrb_q != 4'd0) && !err_q && !reset_i;

  // NOTE: the RAM array has no reset; its contents survive reset and start undefined.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (wstrb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

  assign iomem_ready = (state == S_RESP);
  assign iomem_rdata = iomem_ready ? rd_q : 32'd0;
  assign iomem_err   = iomem_ready & err_q;

endmodule

// File: tb/tb_iomem_responder.sv
// Randomized self-checking bench for iomem_responder against a transaction-level model,
// with directed cases pinning latency and data for WAIT_CYCLES=3.
module tb_iomem_responder;

  localparam int W = 3;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        iomem_err;

  int vectors = 0;
  int misses  = 0;
  bit started = 1'b0;

  iomem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W), .BASE_ADDR(32'h0)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .iomem_err  (iomem_err)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request accepted while idle completes W+1 edges later;
  // its RAM effect happens at the edge before the response cycle unless reset is high.
  logic [31:0] mem_m   [1024];
  logic [31:0] known_m [1024];
  bit          m_active = 1'b0;
  int          m_cnt    = 0;
  logic [31:0] m_addr, m_wdata, m_rdata, m_known;
  logic [3:0]  m_wstrb;
  bit          m_err;

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef IOMEM_RESP_ERR_EN
    return a >= 32'h0000_1000;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk_i) begin
    if (reset_i) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
    end else if (!m_active) begin
      if (iomem_valid) begin
        m_active <= 1'b1;
        m_cnt    <= W + 1;
        m_addr   <= iomem_addr;
        m_wstrb  <= iomem_wstrb;
        m_wdata  <= iomem_wdata;
        m_err    <= out_of_range(iomem_addr);
      end
    end else if (m_cnt == 0) begin
      m_active <= 1'b0;
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !m_err) begin
        if (m_wstrb != 4'd0) begin
          for (int i = 0; i < 4; i++)
            if (m_wstrb[i]) begin
              mem_m[m_addr[11:2]][8*i +: 8]   <= m_wdata[8*i +: 8];
              known_m[m_addr[11:2]][8*i +: 8] <= 8'hFF;
            end
        end else begin
          m_rdata <= mem_m[m_addr[11:2]];
          m_known <= known_m[m_addr[11:2]];
        end
      end
    end
  end

  // Compare process: every cycle, outputs versus the model.
  always @(negedge clk_i) begin
    if (started) begin
      logic        exp_ready, exp_err;
      logic [31:0] exp_rdata, mask;
      exp_ready = m_active && (m_cnt == 0);
      exp_err   = exp_ready && m_err;
      exp_rdata = (exp_ready && m_wstrb == 4'd0 && !m_err) ? m_rdata : 32'd0;
      mask      = (exp_ready && m_wstrb == 4'd0 && !m_err) ? m_known : 32'hFFFF_FFFF;
      check("ready", {31'd0, iomem_ready}, {31'd0, exp_ready});
      check("err",   {31'd0, iomem_err},   {31'd0, exp_err});
      check("rdata", iomem_rdata & mask,   exp_rdata & mask);
    end
  end

  // One request; lat is the cycle of the ready pulse counted from the sample cycle, -1 if none.
  task automatic req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     input int drop_at, input int reset_at,
                     output logic [31:0] rd, output logic e, output int lat);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    lat = -1;
    rd  = 32'd0;
    e   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (iomem_ready) begin
        lat = k;
        rd  = iomem_rdata;
        e   = iomem_err;
        break;
      end
      if (k == 1) begin
        iomem_addr  = $urandom;
        iomem_wdata = $urandom;
        iomem_wstrb = 4'($urandom);
      end
      if (k == drop_at) iomem_valid = 1'b0;
      if (k == reset_at) reset_i = 1'b1;
      if (reset_at >= 0 && k == reset_at + 1) begin
        reset_i     = 1'b0;
        iomem_valid = 1'b0;
      end
      if (reset_at >= 0 && k == reset_at + W + 4) break;
    end
    @(posedge clk_i);
    #1;
    iomem_valid = 1'b0;
    if (reset_at < 0) check("latency", lat, W + 2);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    for (int i = 0; i < 1024; i++) known_m[i] = 32'd0;
    reset_i     = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
    iomem_addr  = 32'd0;
    iomem_wdata = 32'd0;
    @(posedge clk_i);
    started = 1'b1;
    @(posedge clk_i);
    #1;
    check("reset_ready", {31'd0, iomem_ready}, 32'd0);
    check("reset_rdata", iomem_rdata, 32'd0);
    check("reset_err",   {31'd0, iomem_err}, 32'd0);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    req(32'h10, 4'hF, 32'h1234_5678, -1, -1, rd, e, lat);
    check("wr_lat5", lat, 5);
    check("wr_err", {31'd0, e}, 32'd0);
    check("wr_rdata0", rd, 32'd0);
    req(32'h10, 4'h0, 32'h0, -1, -1, rd, e, lat);
    check("rd_full", rd, 32'h1234_5678);
    check("rd_lat5", lat, 5);
    req(32'h10, 4'b0010, 32'h0000_AB00, -1, -1, rd, e, lat);
    req(32'h12, 4'h0, 32'h0, -1, -1, rd, e, lat);
    check("rd_byte", rd, 32'h1234_AB78);

    req(32'h10, 4'hF, 32'hFFFF_FFFF, -1, 2, rd, e, lat);
    check("reset_no_ready", lat, -1);
    req(32'h10, 4'h0, 32'h0, -1, -1, rd, e, lat);
    check("rd_after_reset", rd, 32'h1234_AB78);

    req(32'h0, 4'hF, 32'hCAFE_F00D, -1, -1, rd, e, lat);
    req(32'h1000, 4'h0, 32'h0, -1, -1, rd, e, lat);
`ifdef IOMEM_RESP_ERR_EN
    check("oor_err", {31'd0, e}, 32'd1);
    check("oor_rdata", rd, 32'd0);
`else
    check("alias_err", {31'd0, e}, 32'd0);
    check("alias_rdata", rd, 32'hCAFE_F00D);
`endif

    req(32'h10, 4'h0, 32'h0, 1, -1, rd, e, lat);
    check("drop_lat", lat, 5);
    check("drop_rdata", rd, 32'h1234_AB78);

    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      logic [3:0]  s;
      int          drop, rst;
      a    = {28'd0, 4'($urandom_range(0, 15))} << 2;
      a    = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h1000;
      s    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W + 1) : -1;
      rst  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, W + 1) : -1;
      req(a, s, $urandom, drop, rst, rd, e, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end

    repeat (4) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
